// File: rtl/sram_like_responder.sv
// rtl/sram_like_responder.sv - in-order SRAM-like responder with request queue and programmable latency
module sram_like_responder #(
    parameter int ADDR_W  = 10,
    parameter int QDEPTH  = 2,
    parameter int LATENCY = 1
) (
    input  logic        i_clk,
    input  logic        i_resetn,
    input  logic        i_req,
    input  logic        i_wr,
    input  logic [1:0]  i_size,
    input  logic [3:0]  i_wstrb,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic        i_stall_addr,
    input  logic        i_stall_data,
    output logic        o_addr_ok,
    output logic        o_data_ok,
    output logic [31:0] o_rdata
);

    localparam int                PTR_W    = 2;
    localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(QDEPTH - 1);
    localparam logic [2:0]        FULL_CNT = 3'(QDEPTH);
    localparam logic [3:0]        CD_INIT  = 4'(LATENCY - 1);

    logic [31:0]       r_mem [2**ADDR_W];

    logic              r_q_wr   [4];
    logic [ADDR_W-1:0] r_q_idx  [4];
    logic [3:0]        r_q_strb [4];
    logic [31:0]       r_q_data [4];
    logic [3:0]        r_q_cd   [4];

    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [2:0]        r_count;
    logic              r_data_ok;
    logic [31:0]       r_rdata;

    logic              w_push;
    logic              w_store;
    logic              w_pop;
    logic              w_bypass;
    logic              w_retire;
    logic              w_head_ready;
    logic [ADDR_W-1:0] w_in_idx;
    logic              w_ret_wr;
    logic [ADDR_W-1:0] w_ret_idx;
    logic [3:0]        w_ret_strb;
    logic [31:0]       w_ret_data;
    logic              w_unused;

    assign w_unused  = ^{i_size, i_addr[31:ADDR_W+2], i_addr[1:0]};
    assign w_in_idx  = i_addr[ADDR_W+1:2];

    assign o_addr_ok = (r_count != FULL_CNT) && !i_stall_addr;
    assign o_data_ok = r_data_ok;
    assign o_rdata   = r_rdata;

    assign w_push = i_req && o_addr_ok;

    // Countdown is checked as it will stand after this edge's decrement, so a
    // request accepted at edge E retires at edge E+LATENCY-1; with LATENCY=1 an
    // incoming request on an empty queue retires at its own acceptance edge.
    assign w_head_ready = (r_count != 3'd0) && (r_q_cd[r_head] <= 4'd1);
    assign w_pop        = w_head_ready && !i_stall_data;
    assign w_bypass     = (r_count == 3'd0) && w_push && (CD_INIT == 4'd0) && !i_stall_data;
    assign w_retire     = w_pop || w_bypass;
    assign w_store      = w_push && !w_bypass;

    assign w_ret_wr   = w_pop ? r_q_wr[r_head]   : i_wr;
    assign w_ret_idx  = w_pop ? r_q_idx[r_head]  : w_in_idx;
    assign w_ret_strb = w_pop ? r_q_strb[r_head] : i_wstrb;
    assign w_ret_data = w_pop ? r_q_data[r_head] : i_wdata;

    // Memory is deliberately outside the reset domain: contents survive reset.
    always_ff @(posedge i_clk) begin
        if (w_retire && w_ret_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (w_ret_strb[i]) begin
                    r_mem[w_ret_idx][8*i +: 8] <= w_ret_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_data_ok <= 1'b0;
            r_rdata   <= '0;
            for (int i = 0; i < 4; i++) begin
                r_q_wr[i]   <= 1'b0;
                r_q_idx[i]  <= '0;
                r_q_strb[i] <= '0;
                r_q_data[i] <= '0;
                r_q_cd[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (r_q_cd[i] != 4'd0) begin
                    r_q_cd[i] <= r_q_cd[i] - 4'd1;
                end
            end

            if (w_store) begin
                r_q_wr[r_tail]   <= i_wr;
                r_q_idx[r_tail]  <= w_in_idx;
                r_q_strb[r_tail] <= i_wstrb;
                r_q_data[r_tail] <= i_wdata;
                r_q_cd[r_tail]   <= CD_INIT;
                r_tail           <= (r_tail == LAST_PTR) ? '0 : r_tail + 1'b1;
            end

            if (w_pop) begin
                r_head <= (r_head == LAST_PTR) ? '0 : r_head + 1'b1;
            end

            case ({w_store, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase

            r_data_ok <= w_retire;
            if (w_retire) begin
                r_rdata <= w_ret_wr ? 32'h0 : r_mem[w_ret_idx];
            end
        end
    end

endmodule
